cmac_sched: RTL and testbench

- Sequencer for the complex multiply-accumulate datapath that computes a ROWS x COLS result matrix. Each result is an inner product of length DEPTH over split real/imag sample memories.
- Generates the operand read addresses, MAC enable and accumulator-clear strobes, and waits out the datapath pipeline.
- Presents each finished element's index with a valid/ready handshake to the result store, then signals completion.
- Sits between the sample-load logic (asserts start once both memories are full) and the MAC/result-buffer datapath.

---
 rtl/cmac_sched.sv | 194 +++++++++++++++++++
 tb/tb_cmac_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_sched.sv
// Sequencer for the complex MAC datapath: walks ROWS x COLS elements, DEPTH beats each, then drains and writes.
// Latency: first beat one cycle after start; each element costs DEPTH+PIPE_LAT+1 cycles when res_ready is high.
// Backpressure: WRITE holds res_valid/res_idx until res_ready; no beats are issued while waiting.
module cmac_sched #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DEPTH    = 64,
  parameter int IMAG_OFS = 256,
  parameter int AW       = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          res_ready,
  output logic          busy,
  output logic          done,
  output logic          mac_en,
  output logic          acc_clr,
  output logic [AW-1:0] s_real_addr,
  output logic [AW-1:0] s_imag_addr,
  output logic [AW-1:0] k_real_addr,
  output logic [AW-1:0] k_imag_addr,
  output logic          res_valid,
  output logic [7:0]    res_idx
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]    state, state_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic [KW-1:0] k, k_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic          busy_n, done_n, mac_n, clr_n, rv_n;
  logic [7:0]    idx_n;
  logic [AW-1:0] sr_n, si_n, kr_n, ki_n;
  logic          beat, clear;

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    k_n     = k;
    pcnt_n  = pcnt;
    busy_n  = busy;
    done_n  = 1'b0;
    mac_n   = 1'b0;
    clr_n   = 1'b0;
    rv_n    = res_valid;
    idx_n   = res_idx;
    sr_n    = s_real_addr;
    si_n    = s_imag_addr;
    kr_n    = k_real_addr;
    ki_n    = k_imag_addr;
    beat    = 1'b0;
    clear   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          busy_n  = 1'b1;
          row_n   = '0;
          col_n   = '0;
          k_n     = '0;
          beat    = 1'b1;
        end
      end
      ISSUE: begin
        if (k == KW'(DEPTH - 1)) begin
          k_n    = '0;
          pcnt_n = '0;
          if (PIPE_LAT == 0) begin
            state_n = WRITE;
            rv_n    = 1'b1;
            idx_n   = 8'(32'(row) * COLS + 32'(col));
          end else begin
            state_n = DRAIN;
          end
        end else begin
          k_n  = k + KW'(1);
          beat = 1'b1;
        end
      end
      DRAIN: begin
        if (pcnt == PW'(PIPE_LAT - 1)) begin
          state_n = WRITE;
          rv_n    = 1'b1;
          idx_n   = 8'(32'(row) * COLS + 32'(col));
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end
      WRITE: begin
        if (res_ready) begin
          rv_n = 1'b0;
          if (col != CW'(COLS - 1)) begin
            col_n   = col + CW'(1);
            state_n = ISSUE;
            beat    = 1'b1;
          end else if (row != RW'(ROWS - 1)) begin
            col_n   = '0;
            row_n   = row + RW'(1);
            state_n = ISSUE;
            beat    = 1'b1;
          end else begin
            state_n = FIN;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      default: clear = 1'b1;
    endcase

    if (beat) begin
      mac_n = 1'b1;
      clr_n = (k_n == '0);
      sr_n  = AW'(32'(row_n) * DEPTH + 32'(k_n));
      kr_n  = AW'(32'(col_n) * DEPTH + 32'(k_n));
      si_n  = sr_n + AW'(IMAG_OFS);
      ki_n  = kr_n + AW'(IMAG_OFS);
    end

    // abort outranks acceptance and every other transition
    if (abort && state != IDLE) clear = 1'b1;

    if (clear) begin
      state_n = IDLE;
      row_n   = '0;
      col_n   = '0;
      k_n     = '0;
      pcnt_n  = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      mac_n   = 1'b0;
      clr_n   = 1'b0;
      rv_n    = 1'b0;
      idx_n   = '0;
      sr_n    = '0;
      si_n    = '0;
      kr_n    = '0;
      ki_n    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      k           <= '0;
      pcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mac_en      <= 1'b0;
      acc_clr     <= 1'b0;
      res_valid   <= 1'b0;
      res_idx     <= '0;
      s_real_addr <= '0;
      s_imag_addr <= '0;
      k_real_addr <= '0;
      k_imag_addr <= '0;
    end else begin
      state       <= state_n;
      row         <= row_n;
      col         <= col_n;
      k           <= k_n;
      pcnt        <= pcnt_n;
      busy        <= busy_n;
      done        <= done_n;
      mac_en      <= mac_n;
      acc_clr     <= clr_n;
      res_valid   <= rv_n;
      res_idx     <= idx_n;
      s_real_addr <= sr_n;
      s_imag_addr <= si_n;
      k_real_addr <= kr_n;
      k_imag_addr <= ki_n;
    end
  end

endmodule

// File: tb/tb_cmac_sched.sv
// Bench for cmac_sched: fixed-cycle vector table on a clean pass, element-walk reference model under random backpressure.
module tb_cmac_sched;
  localparam int ROWS = 4, COLS = 4, DEPTH = 64, IMAG_OFS = 256, AW = 10, PIPE_LAT = 2;
  localparam int AMASK = (1 << AW) - 1;
  localparam int ELEM_CYC = DEPTH + PIPE_LAT + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic busy, done, mac_en, acc_clr, res_valid;
  logic [AW-1:0] s_real_addr, s_imag_addr, k_real_addr, k_imag_addr;
  logic [7:0] res_idx;

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;

  cmac_sched #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .IMAG_OFS(IMAG_OFS), .AW(AW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .res_ready(res_ready),
    .busy(busy), .done(done), .mac_en(mac_en), .acc_clr(acc_clr),
    .s_real_addr(s_real_addr), .s_imag_addr(s_imag_addr),
    .k_real_addr(k_real_addr), .k_imag_addr(k_imag_addr),
    .res_valid(res_valid), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit chk_addr;
    bit mac; bit clr; bit rv; bit bsy; bit dn;
    int idx; int sr; int si; int kr; int ki;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc - t0, act, exp_v);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mac"}, mac_en, 0);
    chk({tag, "_clr"}, acc_clr, 0);
    chk({tag, "_rv"}, res_valid, 0);
    chk({tag, "_idx"}, res_idx, 0);
    chk({tag, "_sr"}, s_real_addr, 0);
    chk({tag, "_si"}, s_imag_addr, 0);
    chk({tag, "_kr"}, k_real_addr, 0);
    chk({tag, "_ki"}, k_imag_addr, 0);
  endtask

  // Reference walk: element by element, DEPTH beats, PIPE_LAT quiet cycles, then a write held until accepted.
  // mode 0: ready always; 1: random ready; 2: ready withheld 5 cycles on element 3.
  task automatic run_pass(input int mode, input bit spam);
    int waits_total, waits, r, c, base_s, base_k;
    bit rdy;
    waits_total = 0;
    start = 1'b1;
    t0 = cyc;
    tick();
    for (int e = 0; e < ROWS * COLS; e++) begin
      r = e / COLS;
      c = e % COLS;
      for (int kk = 0; kk < DEPTH; kk++) begin
        chk("beat_mac", mac_en, 1);
        chk("beat_clr", acc_clr, (kk == 0) ? 1 : 0);
        chk("beat_sr", s_real_addr, (r * DEPTH + kk) & AMASK);
        chk("beat_si", s_imag_addr, (r * DEPTH + kk + IMAG_OFS) & AMASK);
        chk("beat_kr", k_real_addr, (c * DEPTH + kk) & AMASK);
        chk("beat_ki", k_imag_addr, (c * DEPTH + kk + IMAG_OFS) & AMASK);
        chk("beat_busy", busy, 1);
        chk("beat_rv", res_valid, 0);
        start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        res_ready = 1'($urandom_range(0, 1));
        tick();
      end
      base_s = r * DEPTH + DEPTH - 1;
      base_k = c * DEPTH + DEPTH - 1;
      for (int p = 0; p < PIPE_LAT; p++) begin
        chk("drain_mac", mac_en, 0);
        chk("drain_rv", res_valid, 0);
        chk("drain_sr", s_real_addr, base_s & AMASK);
        chk("drain_ki", k_imag_addr, (base_k + IMAG_OFS) & AMASK);
        chk("drain_busy", busy, 1);
        start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      waits = 0;
      do begin
        chk("write_rv", res_valid, 1);
        chk("write_idx", res_idx, e);
        chk("write_mac", mac_en, 0);
        chk("write_busy", busy, 1);
        chk("write_done", done, 0);
        case (mode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 2) != 0) || (waits >= 6);
          default: rdy = (e != 3) || (waits >= 5);
        endcase
        res_ready = rdy;
        start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!rdy) begin
          waits++;
          waits_total++;
        end
        tick();
      end while (!rdy);
    end
    start = 1'b0;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_rv", res_valid, 0);
    chk("fin_cycle", cyc - t0, ROWS * COLS * ELEM_CYC + 1 + waits_total);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_mac", mac_en, 0);
  endtask

  vec_t tab[10];

  initial begin
    tab[0] = '{1,    1, 1, 1, 0, 1, 0, 0,  0, 256,   0, 256};
    tab[1] = '{2,    1, 1, 0, 0, 1, 0, 0,  1, 257,   1, 257};
    tab[2] = '{64,   1, 1, 0, 0, 1, 0, 0, 63, 319,  63, 319};
    tab[3] = '{65,   1, 0, 0, 0, 1, 0, 0, 63, 319,  63, 319};
    tab[4] = '{66,   1, 0, 0, 0, 1, 0, 0, 63, 319,  63, 319};
    tab[5] = '{67,   1, 0, 0, 1, 1, 0, 0, 63, 319,  63, 319};
    tab[6] = '{68,   1, 1, 1, 0, 1, 0, 0,  0, 256,  64, 320};
    tab[7] = '{403,  1, 1, 1, 0, 1, 0, 0, 64, 320, 128, 384};
    tab[8] = '{1072, 1, 0, 0, 1, 1, 0, 15, 255, 511, 255, 511};
    tab[9] = '{1073, 0, 0, 0, 0, 0, 1, 0,  0,   0,   0,   0};

    #1 rst = 1'b0;
    #3 chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_zero("post_reset");

    // clean pass against the fixed-cycle table
    res_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    for (int c = 1; c <= 1075; c++) begin
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (tab[i].cyc == c) begin
          chk("tab_mac", mac_en, tab[i].mac);
          chk("tab_clr", acc_clr, tab[i].clr);
          chk("tab_rv", res_valid, tab[i].rv);
          chk("tab_busy", busy, tab[i].bsy);
          chk("tab_done", done, tab[i].dn);
          if (tab[i].rv) chk("tab_idx", res_idx, tab[i].idx);
          if (tab[i].chk_addr) begin
            chk("tab_sr", s_real_addr, tab[i].sr);
            chk("tab_si", s_imag_addr, tab[i].si);
            chk("tab_kr", k_real_addr, tab[i].kr);
            chk("tab_ki", k_imag_addr, tab[i].ki);
          end
        end
      end
    end

    run_pass(0, 1'b0);
    run_pass(2, 1'b0);
    run_pass(0, 1'b1);
    run_pass(1, 1'b0);
    run_pass(1, 1'b1);

    // abort on element 5, k=20
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    res_ready = 1'b1;
    while (cyc - t0 < 5 * ELEM_CYC + 1 + 20) tick();
    chk("abort_pre_mac", mac_en, 1);
    chk("abort_pre_sr", s_real_addr, 84);
    chk("abort_pre_kr", k_real_addr, 84);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_zero("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_idle_busy", busy, 0);
    end
    run_pass(0, 1'b0);

    // asynchronous reset in the middle of DRAIN
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc - t0 < DEPTH + 1) tick();
    chk("drain_pre_busy", busy, 1);
    chk("drain_pre_mac", mac_en, 0);
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    run_pass(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
